// File: rtl/square_ctrl_pkg.sv
// Shared types and constants for the square-wave voice controller.
package square_ctrl_pkg;

  localparam int VOL_W = 6;
  localparam logic [VOL_W-1:0] VOL_MAX = 6'd63;

  typedef enum logic [1:0] {
    NOP      = 2'd0,
    NOTE_ON  = 2'd1,
    NOTE_OFF = 2'd2,
    SET_VOL  = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ATTACK,
    SUSTAIN,
    RELEASE
  } env_state_e;

endpackage

// File: rtl/tick_divider.sv
// Free-running envelope tempo divider: one-cycle tick every TICK_DIV clocks.
module tick_divider #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_active_high,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst_active_high) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/square_voice_ctrl.sv
// Per-voice note controller: command handshake, linear A/S/R volume envelope,
// and frequency/volume/phase-restart drive for one DDS square generator.
module square_voice_ctrl
  import square_ctrl_pkg::*;
#(
  parameter int PHASE_WIDTH = 32,
  parameter int TICK_DIV    = 50000
) (
  input  logic                   clk,
  input  logic                   rst_active_high,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [PHASE_WIDTH-1:0] cmd_freq,
  input  logic [VOL_W-1:0]       cmd_vol,
  input  logic [3:0]             cmd_attack,
  input  logic [3:0]             cmd_release,
  output logic [PHASE_WIDTH-1:0] freq_word,
  output logic [VOL_W-1:0]       vol,
  output logic                   dds_phase_rst,
  output logic                   busy
);

  env_state_e             state, state_n;
  logic [PHASE_WIDTH-1:0] freq_n;
  logic [VOL_W-1:0]       vol_n, target, target_n;
  logic [3:0]             attack_rate, attack_n, rel_rate, rel_n, rate, rate_n;
  logic                   tick, accept, acted;

  tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk             (clk),
    .rst_active_high (rst_active_high),
    .tick            (tick)
  );

  assign cmd_ready     = (state != LOAD);
  assign busy          = (state != IDLE);
  assign dds_phase_rst = (state == LOAD);
  assign accept        = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (rst_active_high) begin
      state       <= IDLE;
      freq_word   <= '0;
      vol         <= '0;
      target      <= '0;
      attack_rate <= '0;
      rel_rate    <= '0;
      rate        <= '0;
    end else begin
      state       <= state_n;
      freq_word   <= freq_n;
      vol         <= vol_n;
      target      <= target_n;
      attack_rate <= attack_n;
      rel_rate    <= rel_n;
      rate        <= rate_n;
    end
  end

  // A command that changes anything overrides the envelope step of that cycle.
  always_comb begin
    state_n  = state;
    freq_n   = freq_word;
    vol_n    = vol;
    target_n = target;
    attack_n = attack_rate;
    rel_n    = rel_rate;
    rate_n   = rate;
    acted    = 1'b0;

    if (accept) begin
      case (cmd_op_e'(cmd_op))
        NOTE_ON: begin
          acted    = 1'b1;
          freq_n   = cmd_freq;
          target_n = cmd_vol;
          attack_n = cmd_attack;
          rel_n    = cmd_release;
          vol_n    = '0;
          state_n  = LOAD;
        end
        NOTE_OFF: begin
          if (state == ATTACK || state == SUSTAIN) begin
            acted  = 1'b1;
            rate_n = '0;
            if (rel_rate == 4'd0) begin
              vol_n   = '0;
              state_n = IDLE;
            end else begin
              state_n = RELEASE;
            end
          end
        end
        SET_VOL: begin
          acted    = 1'b1;
          target_n = cmd_vol;
          if (state == SUSTAIN) begin
            vol_n = cmd_vol;
          end else if (state == ATTACK && cmd_vol <= vol) begin
            vol_n   = cmd_vol;
            state_n = SUSTAIN;
          end
        end
        default: ;
      endcase
    end

    if (!acted) begin
      case (state)
        LOAD: begin
          rate_n = '0;
          if (target == '0) begin
            state_n = SUSTAIN;
          end else if (attack_rate == 4'd0) begin
            vol_n   = target;
            state_n = SUSTAIN;
          end else begin
            state_n = ATTACK;
          end
        end
        ATTACK: begin
          if (vol >= target || vol == VOL_MAX) begin
            state_n = SUSTAIN;
          end else if (tick) begin
            if (rate == attack_rate - 4'd1) begin
              rate_n = '0;
              vol_n  = vol + 6'd1;
              if (vol + 6'd1 >= target) state_n = SUSTAIN;
            end else begin
              rate_n = rate + 4'd1;
            end
          end
        end
        RELEASE: begin
          if (vol == '0) begin
            state_n = IDLE;
          end else if (tick) begin
            if (rate == rel_rate - 4'd1) begin
              rate_n = '0;
              vol_n  = vol - 6'd1;
              if (vol == 6'd1) state_n = IDLE;
            end else begin
              rate_n = rate + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_square_voice_ctrl.sv
// Directed self-checking bench for square_voice_ctrl with a 4-cycle envelope tick.
module tb_square_voice_ctrl;
  import square_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_active_high = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [31:0] cmd_freq = '0;
  logic [5:0]  cmd_vol = '0;
  logic [3:0]  cmd_attack = '0;
  logic [3:0]  cmd_release = '0;
  logic [31:0] freq_word;
  logic [5:0]  vol;
  logic        dds_phase_rst;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int div = 0;

  square_voice_ctrl #(.PHASE_WIDTH(32), .TICK_DIV(4)) dut (
    .clk             (clk),
    .rst_active_high (rst_active_high),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_freq        (cmd_freq),
    .cmd_vol         (cmd_vol),
    .cmd_attack      (cmd_attack),
    .cmd_release     (cmd_release),
    .freq_word       (freq_word),
    .vol             (vol),
    .dds_phase_rst   (dds_phase_rst),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // Reference tick phase: the coming edge is a tick edge when div==3.
  always @(posedge clk) begin
    if (rst_active_high) div <= 0;
    else div <= (div == 3) ? 0 : div + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_tick();
    bit was;
    int n;
    n = 0;
    do begin
      was = (div == 3);
      step();
      n++;
    end while (!was && n < 8);
  endtask

  task automatic align_to_tick();
    int n;
    n = 0;
    while (div != 3 && n < 8) begin
      step();
      n++;
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] f, input logic [5:0] v,
                      input logic [3:0] a, input logic [3:0] r);
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_freq    = f;
    cmd_vol     = v;
    cmd_attack  = a;
    cmd_release = r;
    step();
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
  endtask

  task automatic test_reset();
    int n;
    rst_active_high = 1'b1;
    step();
    step();
    rst_active_high = 1'b0;
    checks++; if (vol !== 6'd0) begin errors++; $display("[TB] FAIL reset_vol: got %0d expected 0", vol); end
    checks++; if (freq_word !== 32'd0) begin errors++; $display("[TB] FAIL reset_freq: got %0h expected 0", freq_word); end
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || dds_phase_rst !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_flags: got busy=%b ready=%b rst=%b expected 0 1 0", busy, cmd_ready, dds_phase_rst);
    end
    send(NOTE_ON, 32'h0000_abcd, 6'd20, 4'd1, 4'd0);
    step();
    n = 0;
    while (vol != 6'd5 && n < 60) begin
      step();
      n++;
    end
    checks++; if (vol !== 6'd5 || busy !== 1'b1) begin errors++; $display("[TB] FAIL reach_vol5: got vol=%0d busy=%b expected 5 1", vol, busy); end
    rst_active_high = 1'b1;
    step();
    checks++; if (vol !== 6'd0 || freq_word !== 32'd0) begin
      errors++; $display("[TB] FAIL midattack_reset: got vol=%0d freq=%0h expected 0 0", vol, freq_word);
    end
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL midattack_reset_flags: got busy=%b ready=%b expected 0 1", busy, cmd_ready);
    end
    rst_active_high = 1'b0;
    step();
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL post_reset_ready: got ready=%b busy=%b expected 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_note_on();
    send(NOTE_ON, 32'h0100_0000, 6'd3, 4'd1, 4'd2);
    checks++; if (dds_phase_rst !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL load_pulse: got rst=%b ready=%b expected 1 0", dds_phase_rst, cmd_ready);
    end
    checks++; if (freq_word !== 32'h0100_0000 || vol !== 6'd0) begin
      errors++; $display("[TB] FAIL load_outputs: got freq=%0h vol=%0d expected 1000000 0", freq_word, vol);
    end
    step();
    checks++; if (dds_phase_rst !== 1'b0 || cmd_ready !== 1'b1 || vol !== 6'd0) begin
      errors++; $display("[TB] FAIL after_load: got rst=%b ready=%b vol=%0d expected 0 1 0", dds_phase_rst, cmd_ready, vol);
    end
    for (int i = 1; i <= 3; i++) begin
      run_to_tick();
      checks++; if (vol !== 6'(i)) begin errors++; $display("[TB] FAIL attack_step%0d: got %0d expected %0d", i, vol, i); end
    end
    run_to_tick();
    checks++; if (vol !== 6'd3 || busy !== 1'b1) begin
      errors++; $display("[TB] FAIL sustain_hold: got vol=%0d busy=%b expected 3 1", vol, busy);
    end
  endtask

  task automatic test_release();
    logic [5:0] exp_seq [6];
    exp_seq = '{6'd3, 6'd2, 6'd2, 6'd1, 6'd1, 6'd0};
    send(NOTE_OFF, 32'd0, 6'd0, 4'd0, 4'd0);
    checks++; if (vol !== 6'd3 || busy !== 1'b1) begin
      errors++; $display("[TB] FAIL note_off_entry: got vol=%0d busy=%b expected 3 1", vol, busy);
    end
    for (int i = 0; i < 6; i++) begin
      run_to_tick();
      checks++; if (vol !== exp_seq[i]) begin errors++; $display("[TB] FAIL release_tick%0d: got %0d expected %0d", i, vol, exp_seq[i]); end
    end
    checks++; if (busy !== 1'b0 || freq_word !== 32'h0100_0000) begin
      errors++; $display("[TB] FAIL release_done: got busy=%b freq=%0h expected 0 1000000", busy, freq_word);
    end
  endtask

  task automatic test_instant_attack();
    send(NOTE_ON, 32'h0200_0000, 6'd63, 4'd0, 4'd0);
    checks++; if (vol !== 6'd0 || dds_phase_rst !== 1'b1) begin
      errors++; $display("[TB] FAIL instant_load: got vol=%0d rst=%b expected 0 1", vol, dds_phase_rst);
    end
    step();
    checks++; if (vol !== 6'd63) begin errors++; $display("[TB] FAIL instant_vol: got %0d expected 63", vol); end
    send(SET_VOL, 32'd0, 6'd10, 4'd0, 4'd0);
    checks++; if (vol !== 6'd10) begin errors++; $display("[TB] FAIL sustain_set_vol: got %0d expected 10", vol); end
    run_to_tick();
    checks++; if (vol !== 6'd10 || busy !== 1'b1) begin
      errors++; $display("[TB] FAIL sustain_set_vol_hold: got vol=%0d busy=%b expected 10 1", vol, busy);
    end
  endtask

  task automatic test_set_vol_attack();
    send(NOTE_ON, 32'h0000_0300, 6'd20, 4'd1, 4'd0);
    step();
    for (int i = 0; i < 4; i++) run_to_tick();
    checks++; if (vol !== 6'd4) begin errors++; $display("[TB] FAIL attack_to4: got %0d expected 4", vol); end
    send(SET_VOL, 32'd0, 6'd2, 4'd0, 4'd0);
    checks++; if (vol !== 6'd2) begin errors++; $display("[TB] FAIL attack_set_lower: got %0d expected 2", vol); end
    run_to_tick();
    run_to_tick();
    checks++; if (vol !== 6'd2 || busy !== 1'b1) begin
      errors++; $display("[TB] FAIL attack_set_lower_hold: got vol=%0d busy=%b expected 2 1", vol, busy);
    end
  endtask

  task automatic test_retrigger();
    send(NOTE_ON, 32'h0000_0400, 6'd7, 4'd0, 4'd3);
    step();
    send(NOTE_OFF, 32'd0, 6'd0, 4'd0, 4'd0);
    run_to_tick();
    checks++; if (vol !== 6'd7 || busy !== 1'b1) begin
      errors++; $display("[TB] FAIL release_at7: got vol=%0d busy=%b expected 7 1", vol, busy);
    end
    send(NOTE_ON, 32'h0000_0500, 6'd5, 4'd2, 4'd1);
    checks++; if (vol !== 6'd0 || dds_phase_rst !== 1'b1 || freq_word !== 32'h0000_0500) begin
      errors++; $display("[TB] FAIL retrigger: got vol=%0d rst=%b freq=%0h expected 0 1 500", vol, dds_phase_rst, freq_word);
    end
    step();
    checks++; if (dds_phase_rst !== 1'b0) begin errors++; $display("[TB] FAIL retrigger_pulse_len: got %b expected 0", dds_phase_rst); end
  endtask

  task automatic test_idle_hold();
    send(NOTE_ON, 32'h0000_0600, 6'd9, 4'd0, 4'd0);
    step();
    send(NOTE_OFF, 32'd0, 6'd0, 4'd0, 4'd0);
    checks++; if (vol !== 6'd0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL instant_release: got vol=%0d busy=%b expected 0 0", vol, busy);
    end
    cmd_valid = 1'b1;
    cmd_op    = NOTE_OFF;
    for (int i = 0; i < 6; i++) begin
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL idle_ready%0d: got %b expected 1", i, cmd_ready); end
      step();
      checks++; if (vol !== 6'd0 || busy !== 1'b0 || dds_phase_rst !== 1'b0 || freq_word !== 32'h0000_0600) begin
        errors++; $display("[TB] FAIL idle_noop%0d: got vol=%0d busy=%b rst=%b freq=%0h expected 0 0 0 600", i, vol, busy, dds_phase_rst, freq_word);
      end
    end
    cmd_valid = 1'b0;
    cmd_op    = NOP;
  endtask

  task automatic test_cmd_on_tick();
    send(NOTE_ON, 32'h0000_0700, 6'd30, 4'd1, 4'd0);
    step();
    run_to_tick();
    run_to_tick();
    checks++; if (vol !== 6'd2) begin errors++; $display("[TB] FAIL pre_collision: got %0d expected 2", vol); end
    align_to_tick();
    send(SET_VOL, 32'd0, 6'd25, 4'd0, 4'd0);
    checks++; if (vol !== 6'd2) begin errors++; $display("[TB] FAIL collision_step_dropped: got %0d expected 2", vol); end
    run_to_tick();
    checks++; if (vol !== 6'd3 || busy !== 1'b1) begin
      errors++; $display("[TB] FAIL after_collision: got vol=%0d busy=%b expected 3 1", vol, busy);
    end
  endtask

  initial begin
    test_reset();
    test_note_on();
    test_release();
    test_instant_attack();
    test_set_vol_attack();
    test_retrigger();
    test_idle_hold();
    test_cmd_on_tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/square_voice_ctrl.md
Name: square_voice_ctrl

Overview:
- Per-voice note controller sitting directly in front of one DDS square generator.
- Accepts note commands over a valid/ready handshake and drives the generator's frequency word, 6-bit volume and phase-restart pulse.
- Runs a linear attack/sustain/release volume envelope, stepped by an internal tempo tick.
- One instance per tracker channel; the pattern sequencer is the requester.

Parameters:
- PHASE_WIDTH, 32: width of the frequency word, matching the DDS phase accumulator.
- TICK_DIV, 50000: clk cycles per envelope tick (1 kHz at 50 MHz); minimum 2.

Ports:
- clk  in  1  system clock.
- rst_active_high  in  1  synchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command this cycle.
- cmd_op  in  2  0=NOP, 1=NOTE_ON, 2=NOTE_OFF, 3=SET_VOL.
- cmd_freq  in  PHASE_WIDTH  frequency word (NOTE_ON only).
- cmd_vol  in  6  target volume 0..63 (NOTE_ON, SET_VOL).
- cmd_attack  in  4  ticks per +1 volume step; 0 = instant (NOTE_ON only).
- cmd_release  in  4  ticks per -1 volume step; 0 = instant (NOTE_ON only).
- freq_word  out  PHASE_WIDTH  to DDS freq_word; registered.
- vol  out  6  to DDS vol; registered.
- dds_phase_rst  out  1  one-cycle pulse to the DDS reset, restarting its phase.
- busy  out  1  high when state != IDLE.

Behaviour:
- Reset (synchronous, any state): state=IDLE; freq_word=0; vol=0; target, attack and release registers=0; dds_phase_rst=0; tick and rate counters=0; cmd_ready=1 the cycle after reset deasserts.
- Tick divider: free-running count 0..TICK_DIV-1. The tick pulse is high for one cycle when count==TICK_DIV-1, then the count wraps to 0. The divider is not cleared by commands.
- Accept: a command is accepted when cmd_valid && cmd_ready on a rising edge.
  - NOP is accepted and has no effect.
  - cmd_ready=0 only in LOAD.
- States: IDLE, LOAD, ATTACK, SUSTAIN, RELEASE.
- NOTE_ON (accepted in any state):
  - Latch freq_word, target, attack and release; set vol=0; go to LOAD.
  - LOAD lasts exactly 1 cycle with dds_phase_rst=1.
  - From LOAD: if target==0, go to SUSTAIN. Otherwise, if attack==0, go to SUSTAIN with vol=target. Otherwise go to ATTACK. The rate counter is cleared on leaving LOAD.
  - NOTE_ON in ATTACK, SUSTAIN or RELEASE is a retrigger: vol restarts from 0.
- ATTACK:
  - On each tick, increment the rate counter.
  - When rate counter==attack-1 on a tick: vol+=1 and the rate counter clears.
  - When vol reaches target, go to SUSTAIN.
- SUSTAIN: vol holds.
- NOTE_OFF:
  - In ATTACK or SUSTAIN: go to RELEASE and clear the rate counter. If release==0, set vol=0 and go to IDLE instead.
  - In IDLE, LOAD or RELEASE: accepted, no effect.
- RELEASE:
  - Same stepping as ATTACK using release; each step decrements vol.
  - When vol reaches 0, go to IDLE. vol never underflows.
- SET_VOL:
  - Always updates target.
  - In SUSTAIN: vol=cmd_vol on the next cycle.
  - In ATTACK: if cmd_vol <= vol, set vol=cmd_vol and go to SUSTAIN; otherwise the ramp continues to the new target.
  - In IDLE or RELEASE: store only.
- Simultaneous events: a command accepted in the same cycle as a step-causing tick takes precedence; that tick's step is discarded.
- freq_word holds its last NOTE_ON value through RELEASE and IDLE.
- vol is 6-bit unsigned saturating in 0..63; all comparisons are unsigned.
- Latency: command-to-output is 1 cycle for freq_word, vol and dds_phase_rst. The first attack step occurs no earlier than attack ticks after LOAD.

Decomposition:
- Package square_ctrl_pkg:
  - cmd_op_e enum (NOP, NOTE_ON, NOTE_OFF, SET_VOL).
  - env_state_e enum (IDLE, LOAD, ATTACK, SUSTAIN, RELEASE).
  - VOL_W=6 and VOL_MAX=63 constants.
- Sub-module tick_divider (parameter TICK_DIV; ports clk, rst_active_high, tick). This is the only sub-module.

Test Plan (bench uses TICK_DIV=4):
- Reset mid-ATTACK at vol=5 -> next cycle vol=0, freq_word=0, busy=0, cmd_ready=1.
- NOTE_ON freq=0x0100_0000, vol=3, attack=1, release=2 -> dds_phase_rst high 1 cycle, cmd_ready low the same cycle, then vol 1,2,3 on three consecutive ticks, then SUSTAIN at 3.
- From SUSTAIN vol=3 with release=2, NOTE_OFF -> vol 2,1,0 at every 2nd tick, then busy=0. freq_word stays 0x0100_0000.
- NOTE_ON vol=63, attack=0 -> vol=63 one cycle after LOAD. Then SET_VOL 10 -> vol=10 next cycle.
- In ATTACK at vol=4 toward target 20, SET_VOL 2 -> vol=2, state SUSTAIN. Separately, retrigger NOTE_ON during RELEASE at vol=7 -> vol=0 and a dds_phase_rst pulse.
- Hold cmd_valid with NOTE_OFF in IDLE -> accepted every cycle, no output change. A command landing on a step tick -> no step applied that tick.
